// File: rtl/store_mask_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : store_mask_ctrl_if
// Brief   : Request/response handshake and word-memory port of store_mask_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface store_mask_ctrl_if;
    logic        start;
    logic [1:0]  ct;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, ct, addr, wdata, mem_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, busy, done, err
    );

    modport slave (
        input  start, ct, addr, wdata, mem_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_wr, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/store_mask_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : store_mask_ctrl
// Brief   : Word/halfword/byte store engine; partial stores use read-modify-write.
//           Define STORE_ALIGN_CHECK_EN to reject misaligned word/halfword stores.
// Revision: 1.0 - initial release
// ============================================================================
module store_mask_ctrl #(
    parameter int READ_LAT = 1
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    store_mask_ctrl_if.slave  bus
);

    localparam logic [1:0] c_CT_WORD = 2'd0;
    localparam logic [1:0] c_CT_HALF = 2'd1;
    localparam logic [1:0] c_CT_BYTE = 2'd2;
    localparam logic [1:0] c_CT_RSVD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_ct;
    logic [31:0] r_wdata;
    logic [31:0] r_old;
    logic [3:0]  r_cnt;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_misaligned;
    logic        w_reject;

`ifdef STORE_ALIGN_CHECK_EN
    assign w_misaligned = ((bus.ct == c_CT_WORD) && (bus.addr[1:0] != 2'b00)) ||
                          ((bus.ct == c_CT_HALF) && bus.addr[0]);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_reject = (bus.ct == c_CT_RSVD) || w_misaligned;

    // Little-endian lane merge; bits of wd above the lane width are dropped.
    function automatic logic [31:0] f_merge(input logic [1:0]  ct,
                                            input logic [1:0]  lane,
                                            input logic [31:0] old,
                                            input logic [31:0] wd);
        logic [31:0] res;
        res = old;
        case (ct)
            c_CT_HALF: res[{lane[1], 4'b0000} +: 16] = wd[15:0];
            c_CT_BYTE: res[{lane, 3'b000} +: 8]      = wd[7:0];
            default:   res = wd;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_ct     <= '0;
            r_wdata  <= '0;
            r_old    <= '0;
            r_cnt    <= '0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr  <= bus.addr;
                        r_ct    <= bus.ct;
                        r_wdata <= bus.wdata;
                        r_busy  <= 1'b1;
                        if (w_reject) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (bus.ct == c_CT_WORD) begin
                            r_state  <= S_WR;
                            r_mem_wr <= 1'b1;
                        end else begin
                            r_state  <= S_RD;
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_WAIT;
                    r_cnt   <= 4'(READ_LAT - 1);
                end
                S_WAIT: begin
                    // Read data is valid in the last WAIT cycle only.
                    if (r_cnt == 4'd0) begin
                        r_old    <= bus.mem_rdata;
                        r_state  <= S_WR;
                        r_mem_wr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WR: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = {r_addr[31:2], 2'b00};
    assign bus.mem_wdata = f_merge(r_ct, r_addr[1:0], r_old, r_wdata);
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire
